result_checker: RTL and testbench

RESULT_CHECKER -- requirements
Module: result_checker

---
 rtl/result_checker.sv | 131 +++++++++++++
 tb/tb_result_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_checker.sv
// rtl/result_checker.sv - compares a stream of results against reference words
// and reports pass/fail counts, the first mismatch and an idle timeout.
module result_checker #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clock_5,
    input  logic               reset_5,
    input  logic               start_5,
    input  logic [COUNT_W-1:0] num_5,
    input  logic               in_valid_5,
    output logic               in_ready_5,
    input  logic [WIDTH-1:0]   res_5,
    input  logic [WIDTH-1:0]   expect_5,
    output logic [COUNT_W-1:0] pass_count_5,
    output logic [COUNT_W-1:0] fail_count_5,
    output logic [COUNT_W-1:0] first_fail_idx_5,
    output logic [WIDTH-1:0]   first_fail_res_5,
    output logic               busy_5,
    output logic               done_5,
    output logic               error_5,
    output logic               timeout_5
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] num_q, num_d;
    logic [COUNT_W-1:0] pass_q, pass_d;
    logic [COUNT_W-1:0] fail_q, fail_d;
    logic [COUNT_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]   ffres_q, ffres_d;
    logic               error_q, error_d;
    logic               timeout_q, timeout_d;
    logic [COUNT_W-1:0] idle_q, idle_d;

    logic               handshake;
    logic [COUNT_W-1:0] accepted;

    // Accepted count is never more than num_q, so this sum cannot wrap.
    assign accepted  = pass_q + fail_q;
    assign handshake = in_valid_5 && (state_q == RUN);

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        idx_d     = idx_q;
        ffres_d   = ffres_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        idle_d    = idle_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_5) begin
                    num_d     = num_5;
                    pass_d    = '0;
                    fail_d    = '0;
                    idx_d     = '0;
                    ffres_d   = '0;
                    error_d   = 1'b0;
                    timeout_d = 1'b0;
                    idle_d    = '0;
                    state_d   = (num_5 == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (handshake) begin
                    idle_d = '0;
                    if (res_5 == expect_5) begin
                        pass_d = pass_q + 1'b1;
                    end else begin
                        fail_d = fail_q + 1'b1;
                        if (!error_q) begin
                            idx_d   = accepted;
                            ffres_d = res_5;
                            error_d = 1'b1;
                        end
                    end
                    if (accepted + 1'b1 == num_q) begin
                        state_d = DONE;
                    end
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_q + 1'b1 == COUNT_W'(TIMEOUT)) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_5) begin
        if (reset_5) begin
            state_q   <= IDLE;
            num_q     <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            idx_q     <= '0;
            ffres_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            idx_q     <= idx_d;
            ffres_q   <= ffres_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            idle_q    <= idle_d;
        end
    end

    assign in_ready_5       = (state_q == RUN);
    assign busy_5           = (state_q == RUN);
    assign done_5           = (state_q == DONE);
    assign pass_count_5     = pass_q;
    assign fail_count_5     = fail_q;
    assign first_fail_idx_5 = idx_q;
    assign first_fail_res_5 = ffres_q;
    assign error_5          = error_q;
    assign timeout_5        = timeout_q;

endmodule

// File: tb/tb_result_checker.sv
// tb/tb_result_checker.sv - scoreboard bench for result_checker
module tb_result_checker;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num;
    logic          in_valid;
    logic [W-1:0]  res, exp_w;

    logic          a_ready, a_busy, a_done, a_error, a_timeout;
    logic [CW-1:0] a_pass, a_fail, a_idx;
    logic [W-1:0]  a_ffres;
    logic          b_ready, b_busy, b_done, b_error, b_timeout;
    logic [CW-1:0] b_pass, b_fail, b_idx;
    logic [W-1:0]  b_ffres;

    always #5 clk = ~clk;

    result_checker #(.WIDTH(W), .COUNT_W(CW), .TIMEOUT(64)) u_dut (
        .clock_5(clk), .reset_5(rst), .start_5(start), .num_5(num),
        .in_valid_5(in_valid), .in_ready_5(a_ready), .res_5(res), .expect_5(exp_w),
        .pass_count_5(a_pass), .fail_count_5(a_fail), .first_fail_idx_5(a_idx),
        .first_fail_res_5(a_ffres), .busy_5(a_busy), .done_5(a_done),
        .error_5(a_error), .timeout_5(a_timeout)
    );

    result_checker #(.WIDTH(W), .COUNT_W(CW), .TIMEOUT(8)) u_dut_t8 (
        .clock_5(clk), .reset_5(rst), .start_5(start), .num_5(num),
        .in_valid_5(in_valid), .in_ready_5(b_ready), .res_5(res), .expect_5(exp_w),
        .pass_count_5(b_pass), .fail_count_5(b_fail), .first_fail_idx_5(b_idx),
        .first_fail_res_5(b_ffres), .busy_5(b_busy), .done_5(b_done),
        .error_5(b_error), .timeout_5(b_timeout)
    );

    typedef struct {
        int unsigned pass;
        int unsigned fail;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned m_pass, m_fail;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        start = 1'b1;
        num   = n;
        tick();
        start  = 1'b0;
        m_pass = 0;
        m_fail = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        m_pass = 0;
        m_fail = 0;
    endtask

    // Presents one result, waits for acceptance, then compares the counters
    // of the primary instance against the scoreboard entry for that handshake.
    task automatic send(input logic [W-1:0] r, input logic [W-1:0] e);
        exp_t x;
        int   n;
        in_valid = 1'b1;
        res      = r;
        exp_w    = e;
        n = 0;
        while (!a_ready && n < 4) begin
            tick();
            n++;
        end
        if (!a_ready) begin
            check("ready_wait", 64'(a_ready), 64'd1);
        end else begin
            if (r == e) m_pass++;
            else        m_fail++;
            x.pass = m_pass;
            x.fail = m_fail;
            sb_q.push_back(x);
            tick();
            x = sb_q.pop_front();
            check("pass_cnt", 64'(a_pass), 64'(x.pass));
            check("fail_cnt", 64'(a_fail), 64'(x.fail));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; num = '0; in_valid = 1'b0; res = '0; exp_w = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 64'(a_ready), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_pass", 64'(a_pass), 64'd0);
        check("rst_error", 64'(a_error), 64'd0);
        check("rst_timeout", 64'(a_timeout), 64'd0);

        // Clean run, valid held high
        do_start(16'd3);
        check("t1_busy", 64'(a_busy), 64'd1);
        for (int i = 0; i < 3; i++) send(32'h8412, 32'h8412);
        check("t1_done", 64'(a_done), 64'd1);
        check("t1_ready_off", 64'(a_ready), 64'd0);
        check("t1_error", 64'(a_error), 64'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_no_extra", 64'(a_pass), 64'd3);

        // Single mismatch at index 2
        do_start(16'd4);
        check("t2_cleared", 64'(a_pass), 64'd0);
        send(32'h8412, 32'h8412);
        send(32'h8412, 32'h8412);
        send(32'h8413, 32'h8412);
        send(32'h8412, 32'h8412);
        check("t2_idx", 64'(a_idx), 64'd2);
        check("t2_ffres", 64'(a_ffres), 64'h8413);
        check("t2_error", 64'(a_error), 64'd1);
        check("t2_done", 64'(a_done), 64'd1);

        // Gaps in valid
        do_start(16'd2);
        send(32'h1, 32'h1);
        tick();
        tick();
        check("t3_not_done", 64'(a_done), 64'd0);
        send(32'h2, 32'h2);
        check("t3_done", 64'(a_done), 64'd1);
        check("t3_timeout", 64'(a_timeout), 64'd0);
        check("t3_pass", 64'(a_pass), 64'd2);

        // Timeout on the TIMEOUT=8 instance
        do_start(16'd5);
        send(32'h77, 32'h77);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            k = i;
            if (b_done) break;
            tick();
            k = i + 1;
            if (b_done) break;
        end
        k = 0;
        // count precisely from the handshake edge
        check("t4_timeout", 64'(b_timeout), 64'd1);
        check("t4_pass", 64'(b_pass), 64'd1);
        check("t4_busy_a", 64'(a_busy), 64'd1);

        // Zero length on the timed-out instance; primary instance ignores start in RUN
        do_start(16'd0);
        check("t5_done0", 64'(b_done), 64'd1);
        check("t5_to_clr", 64'(b_timeout), 64'd0);
        check("t5_cnt0", 64'(b_pass), 64'd0);
        check("t5_run_ignore", 64'(a_pass), 64'd1);
        check("t5_run_busy", 64'(a_busy), 64'd1);
        do_reset();

        // Exact timeout latency: done appears eight edges after the handshake
        do_start(16'd5);
        send(32'h5, 32'h5);
        k = 0;
        while (!b_done && k < 30) begin
            tick();
            k++;
        end
        check("t4_latency", 64'(k), 64'd8);
        do_reset();

        // Restart clears a prior error
        do_start(16'd1);
        send(32'h9, 32'h8);
        check("t6_error", 64'(a_error), 64'd1);
        do_start(16'd1);
        check("t6_err_clr", 64'(a_error), 64'd0);
        send(32'h9, 32'h9);
        check("t6_pass", 64'(a_pass), 64'd1);
        check("t6_done", 64'(a_done), 64'd1);

        // Reset mid-run
        do_start(16'd4);
        send(32'h3, 32'h3);
        send(32'h4, 32'h5);
        in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_ready", 64'(a_ready), 64'd0);
        check("t7_busy", 64'(a_busy), 64'd0);
        check("t7_done", 64'(a_done), 64'd0);
        check("t7_pass", 64'(a_pass), 64'd0);
        check("t7_fail", 64'(a_fail), 64'd0);
        check("t7_error", 64'(a_error), 64'd0);
        check("t7_ffres", 64'(a_ffres), 64'd0);
        tick();
        in_valid = 1'b0;
        check("t7_still_idle", 64'(a_pass), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
